im_loader: RTL
==============

Name: im_loader

Overview:
- Writer side of the instruction memory: accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Drives the instruction memory write port sequentially from address 0, and holds the pipeline stalled while loading.
- Sits between the host byte source (UART receiver or testbench) and the instruction memory write port.

Parameters:
ADDR_W, 10, word-address width of instruction memory
DEPTH, 1024, number of instruction words; max accepted load length

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse; begins a load when idle, done or error
in_valid  input  1  byte available on in_data
in_data  input  8  stream byte
in_ready  output  1  loader can accept a byte this cycle
im_we  output  1  instruction memory write enable, one-cycle pulse per word
im_waddr  output  ADDR_W  word address being written
im_wdata  output  32  assembled instruction word
cpu_hold  output  1  stall/hold request to pipeline while loading
done  output  1  sticky: load completed successfully
err  output  1  sticky: load aborted (length too large or checksum fail)
words_loaded  output  ADDR_W+1  count of words written in current/last load

Behaviour:
- Reset (async, rst=1): state IDLE; in_ready=0, im_we=0, im_waddr=0, im_wdata=0, cpu_hold=0, done=0, err=0, words_loaded=0. Reset mid-load abandons the load; words already written remain in memory.
- Byte transfer occurs only when in_valid && in_ready at a rising edge.
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N bytes with byte 0 in bits [7:0] of each word.
- States:
  - IDLE: in_ready=0. start -> LEN0. Clears done, err and words_loaded; sets cpu_hold=1.
  - LEN0: in_ready=1; accept -> latch N[7:0], go LEN1.
  - LEN1: in_ready=1; accept -> latch N[15:8].
    - If N==0: go DONE.
    - If N>DEPTH: go ERR.
    - Otherwise go DATA with byte index 0.
  - DATA: in_ready=1; each accepted byte shifts into word lane [8*idx+:8]. On the 4th byte, go WRITE.
  - WRITE: in_ready=0; im_we=1 for exactly one cycle, with im_waddr = current address and im_wdata = assembled word. Then address+1 and words_loaded+1.
    - If words_loaded reaches N: go DONE (or CKSUM when enabled).
    - Otherwise return to DATA.
  - DONE: cpu_hold=0, done=1, in_ready=0. start -> LEN0.
  - ERR: cpu_hold=0, err=1, in_ready=0. start -> LEN0.
- start while in LEN0/LEN1/DATA/WRITE/CKSUM is ignored.
- Throughput: at most 1 byte/cycle in DATA; each word costs 4 byte cycles + 1 WRITE cycle.
- im_waddr is held (not incremented) after the last write. With N==DEPTH the final address is DEPTH-1; no wrap occurs.
- in_valid while in_ready=0: byte is not consumed; the source must hold it.
- Outputs are registered except in_ready and im_we, which decode directly from state.

Optional Feature:
- Macro: IM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, enter CKSUM with in_ready=1 and accept one byte.
  - The byte must equal the XOR of all preceding stream bytes, including LEN_LO/LEN_HI.
  - Match -> DONE; mismatch -> ERR.
  - Words already written are not rolled back.
  - For N==0, CKSUM still follows LEN1.
- Not defined: no CKSUM state; LEN1/WRITE go directly to DONE as above; no checksum logic is synthesised.

Test Plan:
- Reset mid-stream: assert rst during DATA after 2 bytes -> all outputs return to reset values immediately, with no im_we pulse.
- Basic load:
  - Stimulus: start; stream 02 00, 13 05 10 00, 93 05 20 00, in_valid continuous.
  - Response: im_we pulses twice, at addr 0 with 0x00100513 and at addr 1 with 0x00200593; done=1, cpu_hold=0, words_loaded=2.
- Backpressure/gaps: same stream with in_valid toggling every other cycle -> identical writes, no duplicated or dropped bytes. in_ready=0 during each WRITE cycle.
- Boundaries:
  - N=0 (00 00) -> DONE with no im_we.
  - N=1025 (01 04) -> ERR, err=1, no im_we, cpu_hold=0.
  - N=1024 -> last write at addr 1023, done=1.
- start ignored while busy: pulse start during DATA -> load continues unchanged. start after DONE -> done clears, new load restarts at addr 0.
- Checksum (IM_LOADER_CHECKSUM_EN):
  - Stream 01 00 78 56 34 12 then checksum 0x09 (XOR of all six bytes) -> im_we at addr 0 with 0x12345678, done=1.
  - Same stream with checksum 0x00 -> err=1, the word is still written.

Source files
------------

// File: rtl/im_loader.sv
// im_loader: accepts a LEN_LO, LEN_HI, 4*N byte stream and writes little-endian words to instruction memory from address 0.
// Define IM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before the load completes.
module im_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
`ifdef IM_LOADER_CHECKSUM_EN
    , S_CKSUM
`endif
  } state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t          state, nxt;
  logic [7:0]      len_lo;
  logic [15:0]     len_q;
  logic [1:0]      idx;
  logic [15:0]     len_in;
  logic            accept;
  logic            begin_load;
  logic            last_word;
  logic            busy_nxt;
  logic [ADDR_W:0] wl_inc;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]      cks;
`endif

  assign accept     = in_valid && in_ready;
  assign len_in     = {in_data, len_lo};
  assign wl_inc     = words_loaded + 1'b1;
  assign last_word  = (16'(wl_inc) == len_q);
  assign begin_load = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign busy_nxt   = !(nxt == S_IDLE || nxt == S_DONE || nxt == S_ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt      = state;
    in_ready = 1'b0;
    im_we    = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) nxt = S_LEN0;
      end
      S_LEN0: begin
        in_ready = 1'b1;
        if (in_valid) nxt = S_LEN1;
      end
      S_LEN1: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (len_in == 16'd0) begin
`ifdef IM_LOADER_CHECKSUM_EN
            nxt = S_CKSUM;
`else
            nxt = S_DONE;
`endif
          end else if ({1'b0, len_in} > DEPTH_L) begin
            nxt = S_ERR;
          end else begin
            nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (in_valid && idx == 2'd3) nxt = S_WRITE;
      end
      S_WRITE: begin
        im_we = 1'b1;
        if (last_word) begin
`ifdef IM_LOADER_CHECKSUM_EN
          nxt = S_CKSUM;
`else
          nxt = S_DONE;
`endif
        end else begin
          nxt = S_DATA;
        end
      end
`ifdef IM_LOADER_CHECKSUM_EN
      S_CKSUM: begin
        in_ready = 1'b1;
        if (in_valid) nxt = (in_data == cks) ? S_DONE : S_ERR;
      end
`endif
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_waddr     <= '0;
      im_wdata     <= '0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      len_lo       <= '0;
      len_q        <= '0;
      idx          <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
      cks          <= '0;
`endif
    end else begin
      cpu_hold <= busy_nxt;
      done     <= (nxt == S_DONE);
      err      <= (nxt == S_ERR);
      if (begin_load) begin
        im_waddr     <= '0;
        words_loaded <= '0;
        idx          <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
        cks          <= '0;
`endif
      end
      if (accept) begin
        case (state)
          S_LEN0: len_lo <= in_data;
          S_LEN1: len_q  <= len_in;
          S_DATA: begin
            im_wdata[8*idx +: 8] <= in_data;
            idx                  <= idx + 2'd1;
          end
          default: ;
        endcase
`ifdef IM_LOADER_CHECKSUM_EN
        // The checksum byte itself is excluded from the running XOR.
        if (state != S_CKSUM) cks <= cks ^ in_data;
`endif
      end
      // Address stays on the last written word once the count is reached.
      if (state == S_WRITE) begin
        words_loaded <= wl_inc;
        if (!last_word) im_waddr <= im_waddr + 1'b1;
      end
    end
  end

endmodule
